// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: kernel windows, edge flags and frame dimensions.
package conv_pkg;

  localparam int unsigned KERNEL_DIAMETER_N = 5;
  localparam int unsigned PIXEL_W           = 8;
  localparam int unsigned IMG_DIM_W         = 12;

  typedef logic [IMG_DIM_W-1:0] img_dim_t;

  typedef logic [KERNEL_DIAMETER_N-1:0][KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_t;

  // Edge proximity of the window centre: *2 = on the edge, *1 = one pixel in
  typedef struct packed {
    logic n2;
    logic n1;
    logic s2;
    logic s1;
    logic w2;
    logic w1;
    logic e2;
    logic e1;
  } kernel_pos_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pos_state_e;

endpackage

// File: rtl/conv_pos_flags.sv
// Combinational map from centre-pixel row/col and frame size to edge flags and row/frame markers.
module conv_pos_flags #(
  parameter int unsigned IMG_DIM_W = conv_pkg::IMG_DIM_W
) (
  input  logic [IMG_DIM_W-1:0] row_i,
  input  logic [IMG_DIM_W-1:0] col_i,
  input  logic [IMG_DIM_W-1:0] w_i,
  input  logic [IMG_DIM_W-1:0] h_i,
  output conv_pkg::kernel_pos_t pos_c,
  output logic                 eol_c,
  output logic                 eof_c
);

  localparam logic [IMG_DIM_W-1:0] ONE = IMG_DIM_W'(1);
  localparam logic [IMG_DIM_W-1:0] TWO = IMG_DIM_W'(2);

  // The *1 flags on the far edges only exist when the frame is at least two wide/tall
  always_comb begin
    pos_c    = '0;
    pos_c.n2 = (row_i == '0);
    pos_c.n1 = (row_i == ONE);
    pos_c.s2 = (row_i == h_i - ONE);
    pos_c.s1 = (h_i >= TWO) && (row_i == h_i - TWO);
    pos_c.w2 = (col_i == '0);
    pos_c.w1 = (col_i == ONE);
    pos_c.e2 = (col_i == w_i - ONE);
    pos_c.e1 = (w_i >= TWO) && (col_i == w_i - TWO);
    eol_c    = pos_c.e2;
    eof_c    = pos_c.s2 & pos_c.e2;
  end

endmodule

// File: rtl/conv_kernel_pos_gen.sv
// Tags a raster stream of kernel windows with edge flags and frame markers behind a one-deep register slice.
module conv_kernel_pos_gen #(
  parameter int unsigned IMG_DIM_W = conv_pkg::IMG_DIM_W
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [IMG_DIM_W-1:0]  cfg_width_i,
  input  logic [IMG_DIM_W-1:0]  cfg_height_i,
  input  logic                  frame_abort_i,
  input  logic                  in_vld_i,
  input  conv_pkg::kernel_t     in_kernel_i,
  output logic                  in_rdy_o,
  output logic                  out_vld_o,
  output conv_pkg::kernel_t     out_kernel_o,
  output conv_pkg::kernel_pos_t out_kernel_pos_o,
  output logic                  out_sof_o,
  output logic                  out_eol_o,
  output logic                  out_eof_o,
  input  logic                  out_rdy_i,
  output logic                  busy_o
);

  import conv_pkg::*;

  typedef logic [IMG_DIM_W-1:0] dim_t;
  localparam dim_t ONE = dim_t'(1);

  pos_state_e  state_q, state_d;
  dim_t        w_q, h_q, row_q, col_q, row_d, col_d, cur_w, cur_h;
  logic        accept, load, last_col, last_row;
  kernel_pos_t pos_c;
  logic        eol_c, eof_c;

  assign in_rdy_o = ~out_vld_o | out_rdy_i;
  assign accept   = in_vld_i & in_rdy_o;
  assign load     = accept & ~frame_abort_i;

  // Live config while idle, latched config mid-frame; a zero dimension behaves as one
  always_comb begin
    cur_w = w_q;
    cur_h = h_q;
    if (state_q == ST_IDLE) begin
      cur_w = (cfg_width_i  == '0) ? ONE : cfg_width_i;
      cur_h = (cfg_height_i == '0) ? ONE : cfg_height_i;
    end
  end

  assign last_col = (col_q == cur_w - ONE);
  assign last_row = (row_q == cur_h - ONE);

  conv_pos_flags #(
    .IMG_DIM_W (IMG_DIM_W)
  ) u_flags (
    .row_i (row_q),
    .col_i (col_q),
    .w_i   (cur_w),
    .h_i   (cur_h),
    .pos_c (pos_c),
    .eol_c (eol_c),
    .eof_c (eof_c)
  );

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d == ST_ACTIVE);
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load && !(last_row && last_col)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (frame_abort_i)                        state_d = ST_IDLE;
        else if (accept && last_row && last_col)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter advance; abort zeroes progress whether or not a beat is offered
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (frame_abort_i) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Counters, latched geometry and output register slice
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      row_q            <= '0;
      col_q            <= '0;
      w_q              <= ONE;
      h_q              <= ONE;
      out_vld_o        <= 1'b0;
      out_kernel_o     <= '0;
      out_kernel_pos_o <= '0;
      out_sof_o        <= 1'b0;
      out_eol_o        <= 1'b0;
      out_eof_o        <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (load && state_q == ST_IDLE) begin
        w_q <= cur_w;
        h_q <= cur_h;
      end
      if (load) begin
        out_vld_o        <= 1'b1;
        out_kernel_o     <= in_kernel_i;
        out_kernel_pos_o <= pos_c;
        out_sof_o        <= (state_q == ST_IDLE);
        out_eol_o        <= eol_c;
        out_eof_o        <= eof_c;
      end else if (out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_kernel_pos_gen.sv
// Directed bench for conv_kernel_pos_gen: frame shapes, stalls, abort, zero config and mid-frame reset.
module tb_conv_kernel_pos_gen;
  import conv_pkg::*;

  logic        clk, arst_n;
  logic [11:0] cfg_width_i, cfg_height_i;
  logic        frame_abort_i, in_vld_i, in_rdy_o, out_vld_o, out_rdy_i;
  logic        out_sof_o, out_eol_o, out_eof_o, busy_o;
  kernel_t     in_kernel_i, out_kernel_o;
  kernel_pos_t out_kernel_pos_o;

  int n_cmp  = 0;
  int n_fail = 0;

  conv_kernel_pos_gen #(.IMG_DIM_W(12)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .cfg_width_i      (cfg_width_i),
    .cfg_height_i     (cfg_height_i),
    .frame_abort_i    (frame_abort_i),
    .in_vld_i         (in_vld_i),
    .in_kernel_i      (in_kernel_i),
    .in_rdy_o         (in_rdy_o),
    .out_vld_o        (out_vld_o),
    .out_kernel_o     (out_kernel_o),
    .out_kernel_pos_o (out_kernel_pos_o),
    .out_sof_o        (out_sof_o),
    .out_eol_o        (out_eol_o),
    .out_eof_o        (out_eof_o),
    .out_rdy_i        (out_rdy_i),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kernel_t mk_kernel(int id);
    kernel_t k;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        k[r][c] = 8'(id * 7 + r * 5 + c);
    return k;
  endfunction

  function automatic kernel_pos_t mkp(bit n2, bit n1, bit s2, bit s1, bit w2, bit w1, bit e2, bit e1);
    kernel_pos_t p;
    p.n2 = n2; p.n1 = n1; p.s2 = s2; p.s1 = s1;
    p.w2 = w2; p.w1 = w1; p.e2 = e2; p.e1 = e1;
    return p;
  endfunction

  // Flags expressed as distance of the centre pixel to each frame edge
  function automatic kernel_pos_t exp_pos(int row, int col, int w, int h);
    int dn, ds, dw, de;
    dn = row; ds = h - 1 - row; dw = col; de = w - 1 - col;
    return mkp(dn == 0, dn == 1, ds == 0, h >= 2 && ds == 1,
               dw == 0, dw == 1, de == 0, w >= 2 && de == 1);
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(string tag, int id, int row, int col, int w, int h, bit sof);
    bit eol, eof;
    eol = (col == w - 1);
    eof = eol && (row == h - 1);
    chk({tag, ".vld"}, out_vld_o, 1'b1);
    chk({tag, ".kernel"}, out_kernel_o, mk_kernel(id));
    chk({tag, ".pos"}, out_kernel_pos_o, exp_pos(row, col, w, h));
    chk({tag, ".mark"}, {out_sof_o, out_eol_o, out_eof_o}, {sof, eol, eof});
  endtask

  task automatic drive(int id, int w, int h);
    cfg_width_i  = 12'(w);
    cfg_height_i = 12'(h);
    in_vld_i     = 1'b1;
    in_kernel_i  = mk_kernel(id);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    in_vld_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n_in, n_out;
    bit stall_prev, fire_in, fire_out;
    logic [255:0] held;

    arst_n = 1'b0; frame_abort_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b1;
    cfg_width_i = 12'd5; cfg_height_i = 12'd4; in_kernel_i = '0;
    @(posedge clk); #1;
    chk("rst.vld", out_vld_o, 1'b0);
    chk("rst.rdy", in_rdy_o, 1'b1);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.data", {out_kernel_o, out_kernel_pos_o, out_sof_o, out_eol_o, out_eof_o}, '0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // 5x4 frame at full rate
    for (int b = 0; b < 20; b++) begin
      drive(b, 5, 4);
      chk_beat("f54", b, b / 5, b % 5, 5, 4, b == 0);
      chk("f54.busy", busy_o, b != 19);
      if (b == 0)  chk("f54.b0",  out_kernel_pos_o, mkp(1,0,0,0,1,0,0,0));
      if (b == 6)  chk("f54.b6",  out_kernel_pos_o, mkp(0,1,0,0,0,1,0,0));
      if (b == 9)  chk("f54.b9",  out_kernel_pos_o, mkp(0,1,0,0,0,0,1,0));
      if (b == 19) chk("f54.b19", out_kernel_pos_o, mkp(0,0,1,0,0,0,1,0));
    end
    idle_cycle();
    chk("f54.drain", out_vld_o, 1'b0);

    // 1x1 frame, then zero config which must behave the same
    drive(30, 1, 1);
    chk_beat("f11", 30, 0, 0, 1, 1, 1'b1);
    chk("f11.pos", out_kernel_pos_o, mkp(1,0,1,0,1,0,1,0));
    chk("f11.busy", busy_o, 1'b0);
    drive(31, 0, 0);
    chk("f00.pos", out_kernel_pos_o, mkp(1,0,1,0,1,0,1,0));
    chk("f00.mark", {out_sof_o, out_eol_o, out_eof_o}, 3'b111);
    chk("f00.busy", busy_o, 1'b0);
    drive(32, 0, 0);
    chk("f00.again", {out_vld_o, out_sof_o}, 2'b11);
    idle_cycle();

    // 2x3 frame
    for (int b = 0; b < 6; b++) begin
      drive(40 + b, 2, 3);
      chk_beat("f23", 40 + b, b / 2, b % 2, 2, 3, b == 0);
      if (b == 0) chk("f23.b0", out_kernel_pos_o, mkp(1,0,0,0,1,0,0,1));
      if (b == 3) chk("f23.b3", out_kernel_pos_o, mkp(0,1,0,1,0,1,1,0));
    end
    idle_cycle();

    // 4x2 frame with downstream ready toggling every cycle
    n_in = 0; n_out = 0; stall_prev = 0; held = '0;
    cfg_width_i = 12'd4; cfg_height_i = 12'd2;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      out_rdy_i   = (cyc % 2 == 0);
      in_vld_i    = (n_in < 8);
      in_kernel_i = mk_kernel(100 + n_in);
      #1;
      if (stall_prev)
        chk("f42.hold", {out_vld_o, out_kernel_o, out_kernel_pos_o, out_sof_o, out_eol_o, out_eof_o}, held);
      fire_in  = in_vld_i & in_rdy_o;
      fire_out = out_vld_o & out_rdy_i;
      if (fire_out) begin
        chk_beat("f42", 100 + n_out, n_out / 4, n_out % 4, 4, 2, n_out == 0);
        n_out++;
      end
      stall_prev = out_vld_o & ~out_rdy_i;
      held = {out_vld_o, out_kernel_o, out_kernel_pos_o, out_sof_o, out_eol_o, out_eof_o};
      if (fire_in) n_in++;
      @(posedge clk); #1;
    end
    chk("f42.count", 32'(n_out), 32'd8);
    out_rdy_i = 1'b1;
    idle_cycle();
    chk("f42.drain", out_vld_o, 1'b0);

    // 8x8 frame: width change mid-frame ignored, abort after beat 10
    for (int b = 0; b < 11; b++) begin
      drive(200 + b, (b < 3) ? 8 : 3, 8);
      chk_beat("f88", 200 + b, b / 8, b % 8, 8, 8, b == 0);
    end
    frame_abort_i = 1'b1;
    drive(250, 3, 8);
    chk("abort.vld", out_vld_o, 1'b0);
    chk("abort.busy", busy_o, 1'b0);
    frame_abort_i = 1'b0;
    drive(251, 3, 8);
    chk_beat("abort.next", 251, 0, 0, 3, 8, 1'b1);
    chk("abort.pos", out_kernel_pos_o, mkp(1,0,0,0,1,0,0,0));
    chk("abort.busy2", busy_o, 1'b1);
    frame_abort_i = 1'b1;
    idle_cycle();
    frame_abort_i = 1'b0;
    idle_cycle();

    // 4x4 frame interrupted by reset at beat 7
    for (int b = 0; b < 7; b++) begin
      drive(300 + b, 4, 4);
      chk_beat("f44", 300 + b, b / 4, b % 4, 4, 4, b == 0);
    end
    in_kernel_i = mk_kernel(307);
    arst_n = 1'b0;
    #1;
    chk("arst.vld", out_vld_o, 1'b0);
    chk("arst.busy", busy_o, 1'b0);
    chk("arst.data", {out_kernel_o, out_kernel_pos_o, out_sof_o, out_eol_o, out_eof_o}, '0);
    @(posedge clk); #1;
    chk("arst.hold", {out_vld_o, busy_o}, 2'b00);
    arst_n = 1'b1;
    #1;
    drive(310, 4, 4);
    chk_beat("arst.next", 310, 0, 0, 4, 4, 1'b1);
    chk("arst.busy2", busy_o, 1'b1);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
